// File: rtl/multu_unit.sv
// Iterative shift-add unsigned multiplier with HI/LO result registers.
// One multiplier bit per cycle; HI/LO are written together only when a product completes.
module multu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             rdhi,
   output logic [WIDTH-1:0] rdata,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] mplier_shift;
   logic             last_iter;

   // Partial-product add; the carry lands in the MSB of acc after the right shift.
   assign sum          = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign acc_shift    = sum[WIDTH:1];
   assign mplier_shift = {sum[0], mplier_q[WIDTH-1:1]};
   assign last_iter    = (state_q == RUN) && (count_q == LAST_CNT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (count_q == LAST_CNT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == RUN);
      done  = done_q;
      rdata = rdhi ? hi_q : lo_q;
   end

   always_comb begin
      count_d  = count_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            mcand_d  = srca;
            mplier_d = srcb;
            acc_d    = '0;
            count_d  = '0;
         end
      end else begin
         acc_d    = acc_shift;
         mplier_d = mplier_shift;
         count_d  = count_q + 1'b1;
         if (last_iter) begin
            hi_d   = acc_shift;
            lo_d   = mplier_shift;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit: constant vector table, hand-built corner
// sequences, and random operands checked against a plain 64-bit product model.
module tb_multu_unit;

   localparam int W = 32;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         rdhi  = 1'b0;
   logic [W-1:0] srca  = '0;
   logic [W-1:0] srcb  = '0;
   logic [W-1:0] rdata;
   logic         busy;
   logic         done;

   multu_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .srca  (srca),
      .srcb  (srcb),
      .rdhi  (rdhi),
      .rdata (rdata),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Product the model says HI/LO currently hold
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic read_hl(output logic [W-1:0] hi, output logic [W-1:0] lo);
      rdhi = 1'b1;
      #1 hi = rdata;
      rdhi = 1'b0;
      #1 lo = rdata;
   endtask

   task automatic chk_result(input string tag, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      logic [W-1:0] h, l;
      read_hl(h, l);
      chk({tag, "_hi"}, h, ehi);
      chk({tag, "_lo"}, l, elo);
   endtask

   // Called at a negedge; returns at the negedge of the first busy cycle.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      srca  = a;
      srcb  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles until done is seen; bounded so a dead DUT cannot hang the run.
   task automatic wait_done(input string tag, input logic [W-1:0] phi, input logic [W-1:0] plo,
                            output int bc, output bit got);
      bc  = 0;
      got = 1'b0;
      for (int i = 0; i < W + 5; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) bc++;
         if (i == W / 2) chk_result({tag, "_during_busy"}, phi, plo);
         @(negedge clk);
      end
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int bc;
      bit got;
      issue(a, b);
      wait_done(tag, exp_hi, exp_lo, bc, got);
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(W));
      chk_result(tag, ehi, elo);
      exp_hi = ehi;
      exp_lo = elo;
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
   endtask

   initial begin
      int bc;
      bit got;
      int extra_done;
      logic [W-1:0] ra, rb;
      logic [63:0]  prod;

      vecs[0] = '{"small",    32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
      vecs[1] = '{"allones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{"zero_a",   32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{"one_x",    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[4] = '{"pow2",     32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

      // Reset state
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk_result("reset_rdata", '0, '0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

      // start re-pulsed mid-run is ignored
      issue(32'h0000_1234, 32'h0000_0010);
      repeat (4) @(negedge clk);
      start = 1'b1;
      srca  = 32'd7;
      srcb  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      srca  = '0;
      srcb  = '0;
      wait_done("restart", exp_hi, exp_lo, bc, got);
      chk("restart_done_seen", 64'(got), 64'd1);
      chk("restart_busy_cycles", 64'(bc), 64'(W - 5));
      chk_result("restart", 32'h0, 32'h0001_2340);
      exp_hi = 32'h0;
      exp_lo = 32'h0001_2340;
      @(negedge clk);
      chk("restart_no_requeue", 64'(busy), 64'd0);

      // start in the done cycle is accepted with no gap
      issue(32'd3, 32'd5);
      wait_done("chain_a", exp_hi, exp_lo, bc, got);
      chk("chain_a_done_seen", 64'(got), 64'd1);
      chk_result("chain_a", 32'h0, 32'h0000_000F);
      exp_hi = 32'h0;
      exp_lo = 32'h0000_000F;
      start = 1'b1;
      srca  = 32'h1234_5678;
      srcb  = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0;
      chk("chain_b_busy", 64'(busy), 64'd1);
      wait_done("chain_b", exp_hi, exp_lo, bc, got);
      chk("chain_b_done_seen", 64'(got), 64'd1);
      chk("chain_b_busy_cycles", 64'(bc), 64'(W));
      chk_result("chain_b", 32'h0B00_EA4E, 32'h242D_2080);
      exp_hi = 32'h0B00_EA4E;
      exp_lo = 32'h242D_2080;
      @(negedge clk);

      // reset during run aborts and clears
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk_result("abort_rdata", '0, '0);
      reset = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      extra_done = 0;
      for (int i = 0; i < W + 8; i++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      chk("abort_no_done", 64'(extra_done), 64'd0);

      // Random operands against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 3) rb = '0;
         if (i == 7) ra = 32'hFFFF_FFFF;
         prod = 64'(ra) * 64'(rb);
         do_op($sformatf("rand%0d", i), ra, rb, prod[63:32], prod[31:0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
